// File: rtl/led_pattern_controller_if.sv
// led_pattern_controller_if: control inputs and LED/mode/tick outputs of the LED sequencer.
// rev 1.0
`default_nettype none

interface led_pattern_controller_if;
  logic        en;
  logic        speed;
  logic        mode_next;
  logic [15:0] led;
  logic [1:0]  mode;
  logic        tick;

  modport master (output en, speed, mode_next, input led, mode, tick);
  modport slave  (input en, speed, mode_next, output led, mode, tick);
endinterface

`default_nettype wire

// File: rtl/led_pattern_controller.sv
// led_pattern_controller: tick prescaler plus rotate/bounce/fill pattern sequencer for 16 LEDs.
// rev 1.0
`default_nettype none

module led_pattern_controller #(
  parameter int FAST_CNT = 16777216,
  parameter int SLOW_CNT = 134217728,
  parameter int CNT_W    = 27
) (
  input  wire logic               clk,
  input  wire logic               rst,
  led_pattern_controller_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_ROTATE = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_CNT - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_CNT - 1);
  localparam logic [15:0]      LED_INIT  = 16'h8000;
  localparam logic             DIR_RIGHT = 1'b0;
  localparam logic             DIR_LEFT  = 1'b1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      led_q, led_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;

  logic [15:0]      step_led;
  logic             step_dir;
  logic             at_limit;

  // >= rather than == so a fast switch with cnt above FAST_LAST steps at once.
  assign at_limit = (cnt_q >= (bus.speed ? SLOW_LAST : FAST_LAST));

  always_comb begin
    step_led = led_q >> 1;
    step_dir = dir_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (dir_q == DIR_RIGHT) begin
          if (led_q == 16'h0001) begin
            step_led = 16'h0002;
            step_dir = DIR_LEFT;
          end
        end else begin
          step_led = led_q << 1;
          if (led_q == 16'h8000) begin
            step_led = 16'h4000;
            step_dir = DIR_RIGHT;
          end
        end
      end
      MODE_FILL: begin
        if (led_q == 16'hFFFF) begin
          step_led = 16'h0000;
        end else begin
          step_led = (led_q >> 1) | 16'h8000;
        end
      end
      default: begin
        if (led_q == 16'h0001) begin
          step_led = 16'h8000;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    led_d  = led_q;
    mode_d = mode_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (bus.mode_next) begin
      case (mode_q)
        MODE_ROTATE: mode_d = MODE_BOUNCE;
        MODE_BOUNCE: mode_d = MODE_FILL;
        default:     mode_d = MODE_ROTATE;
      endcase
      led_d = LED_INIT;
      dir_d = DIR_RIGHT;
      cnt_d = '0;
    end else if (bus.en) begin
      if (at_limit) begin
        cnt_d  = '0;
        led_d  = step_led;
        dir_d  = step_dir;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      led_q  <= LED_INIT;
      mode_q <= MODE_ROTATE;
      dir_q  <= DIR_RIGHT;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      led_q  <= led_d;
      mode_q <= mode_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.mode = mode_q;
  assign bus.tick = tick_q;

endmodule

`default_nettype wire
